// File: rtl/cuidado_mascota.sv
// -----------------------------------------------------------------------------
// cuidado_mascota: virtual-pet care controller.
//
// Four raw active-low pushbuttons (feed, sleep, play, heal) are synchronized,
// debounced and edge-detected into one-cycle press events. A three-state FSM
// (idle, apply, cooldown) accepts one press at a time, raises the matching
// need level by one, then ignores further presses for a cooldown window.
// Decay pulses from an external block lower levels in every state.
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   btn_feed/sleep/play/heal    raw active-low buttons (asynchronous to clk)
//   dec_hambre/sueno/animo/salud  one-cycle decay pulses
//   Nivel_*                     2-bit need levels, 0..3
//   busy                        high whenever the FSM is not idle
//   Led_*                       registered active-low "need attention" LEDs
//
// Internal index order for all four channels:
//   0 = feed/hambre, 1 = sleep/sueno, 2 = play/animo, 3 = heal/salud.
// This order is also the action priority (lowest index wins).
// -----------------------------------------------------------------------------
module cuidado_mascota #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COOLDOWN_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_feed,
    input  logic       btn_sleep,
    input  logic       btn_play,
    input  logic       btn_heal,
    input  logic       dec_animo,
    input  logic       dec_hambre,
    input  logic       dec_sueno,
    input  logic       dec_salud,
    output logic [1:0] Nivel_animo,
    output logic [1:0] Nivel_hambre,
    output logic [1:0] Nivel_sueno,
    output logic [1:0] Nivel_salud,
    output logic       busy,
    output logic       Led_animo,
    output logic       Led_hambre,
    output logic       Led_sueno,
    output logic       Led_salud
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CdW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CdW-1:0] CdLoad = CdW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCooldown
    } state_e;

    logic [3:0] btn_raw;
    logic [3:0] dec_vec;

    assign btn_raw = {btn_heal, btn_play, btn_sleep, btn_feed};
    assign dec_vec = {dec_salud, dec_animo, dec_sueno, dec_hambre};

    // -------------------------------------------------------------------------
    // Two-flop synchronizers (reset to released)
    // -------------------------------------------------------------------------
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncers: count consecutive cycles where the synchronized input
    // disagrees with the accepted level; any agreement restarts the count.
    // -------------------------------------------------------------------------
    logic [3:0]     db_q;
    logic [3:0]     db_d;
    logic [3:0]     db_prev_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q      <= 4'b1111;
            db_prev_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Falling edge of the debounced level only; releases are ignored.
    logic [3:0] press;
    assign press = db_prev_q & ~db_q;

    // -------------------------------------------------------------------------
    // Action FSM
    // -------------------------------------------------------------------------
    state_e         state_q;
    state_e         state_d;
    logic [1:0]     act_q;
    logic [1:0]     act_d;
    logic [CdW-1:0] cd_q;
    logic [CdW-1:0] cd_d;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cd_d    = cd_q;
        unique case (state_q)
            StIdle: begin
                if (|press) begin
                    state_d = StApply;
                    if (press[0]) begin
                        act_d = 2'd0;
                    end else if (press[1]) begin
                        act_d = 2'd1;
                    end else if (press[2]) begin
                        act_d = 2'd2;
                    end else begin
                        act_d = 2'd3;
                    end
                end
            end
            StApply: begin
                cd_d    = CdLoad;
                state_d = StCooldown;
            end
            StCooldown: begin
                if (cd_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cd_d = cd_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            act_q   <= 2'd0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            cd_q    <= cd_d;
        end
    end

    assign busy = (state_q != StIdle);

    // -------------------------------------------------------------------------
    // Need levels: saturating 2-bit; a simultaneous increment and decay cancel.
    // -------------------------------------------------------------------------
    logic [1:0] lvl_q [4];
    logic [1:0] lvl_d [4];
    logic [3:0] inc_vec;
    logic [3:0] led_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inc_vec[i] = (state_q == StApply) && (act_q == 2'(i));
            lvl_d[i]   = lvl_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (lvl_q[i] != 2'd3) begin
                    lvl_d[i] = lvl_q[i] + 2'd1;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (lvl_q[i] != 2'd0) begin
                    lvl_d[i] = lvl_q[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                lvl_q[i] <= 2'd3;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                lvl_q[i] <= lvl_d[i];
                led_q[i] <= (lvl_q[i] == 2'd3);
            end
        end
    end

    assign Nivel_hambre = lvl_q[0];
    assign Nivel_sueno  = lvl_q[1];
    assign Nivel_animo  = lvl_q[2];
    assign Nivel_salud  = lvl_q[3];
    assign Led_hambre   = led_q[0];
    assign Led_sueno    = led_q[1];
    assign Led_animo    = led_q[2];
    assign Led_salud    = led_q[3];

endmodule

// File: tb/tb_cuidado_mascota.sv
// -----------------------------------------------------------------------------
// Testbench for cuidado_mascota (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8).
// A behavioural model tracks the pet from its rules: sync delay, "last N
// samples all disagree" debouncing, a busy-cycle budget per accepted action,
// and clamped level arithmetic.
// -----------------------------------------------------------------------------
module tb_cuidado_mascota;

    localparam int DB = 4;
    localparam int CD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bf = 1'b1, bs = 1'b1, bp = 1'b1, bh = 1'b1;
    logic       da = 1'b0, dh = 1'b0, ds = 1'b0, dsa = 1'b0;
    logic [1:0] Nivel_animo, Nivel_hambre, Nivel_sueno, Nivel_salud;
    logic       busy, Led_animo, Led_hambre, Led_sueno, Led_salud;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cuidado_mascota #(
        .DEBOUNCE_CYCLES(DB),
        .COOLDOWN_CYCLES(CD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_feed    (bf),
        .btn_sleep   (bs),
        .btn_play    (bp),
        .btn_heal    (bh),
        .dec_animo   (da),
        .dec_hambre  (dh),
        .dec_sueno   (ds),
        .dec_salud   (dsa),
        .Nivel_animo (Nivel_animo),
        .Nivel_hambre(Nivel_hambre),
        .Nivel_sueno (Nivel_sueno),
        .Nivel_salud (Nivel_salud),
        .busy        (busy),
        .Led_animo   (Led_animo),
        .Led_hambre  (Led_hambre),
        .Led_sueno   (Led_sueno),
        .Led_salud   (Led_salud)
    );

    logic [12:0] obs;
    assign obs = {Nivel_hambre, Nivel_sueno, Nivel_animo, Nivel_salud, busy,
                  Led_hambre, Led_sueno, Led_animo, Led_salud};

    // ---------------- reference model (index 0 feed,1 sleep,2 play,3 heal) --
    int m_lvl [4];
    bit m_led [4];
    bit m_s1 [4];
    bit m_s2 [4];
    bit m_db [4];
    bit m_hist [4][DB];
    bit m_press [4];
    int m_busy;
    bit m_pend;
    int m_act;

    function automatic logic [12:0] exp_vec();
        logic [12:0] v;
        v = {m_lvl[0][1:0], m_lvl[1][1:0], m_lvl[2][1:0], m_lvl[3][1:0],
             (m_busy > 0), m_led[0], m_led[1], m_led[2], m_led[3]};
        return v;
    endfunction

    task automatic model_edge();
        bit bv [4];
        bit dv [4];
        bit np [4];
        bit allf;
        int v;
        bv = '{bf, bs, bp, bh};
        dv = '{dh, ds, da, dsa};
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] = 3; m_led[i] = 1; m_s1[i] = 1; m_s2[i] = 1;
                m_db[i] = 1; m_press[i] = 0;
                for (int j = 0; j < DB; j++) m_hist[i][j] = 1;
            end
            m_busy = 0;
            m_pend = 0;
            m_act  = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            m_led[i] = (m_lvl[i] == 3);
            v = m_lvl[i] + ((m_pend && m_act == i) ? 1 : 0) - (dv[i] ? 1 : 0);
            m_lvl[i] = (v < 0) ? 0 : (v > 3) ? 3 : v;
        end
        m_pend = 0;
        // One accepted action keeps the pet busy for 1 apply + CD cooldown cycles.
        if (m_busy > 0) begin
            m_busy--;
        end else if (m_press[0] | m_press[1] | m_press[2] | m_press[3]) begin
            m_act = m_press[0] ? 0 : m_press[1] ? 1 : m_press[2] ? 2 : 3;
            m_pend = 1;
            m_busy = CD + 1;
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = DB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s2[i];
            allf = 1;
            for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_db[i]) allf = 0;
            np[i] = 0;
            if (allf) begin
                m_db[i] = !m_db[i];
                np[i]   = !m_db[i];
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = bv[i];
            m_press[i] = np[i];
        end
    endtask

    // Advance one clock: model follows the edge, return at negedge for sampling.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests --
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (obs !== 13'b11111111_0_1111) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, 13'b11111111_0_1111);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_decay_then_feed();
        int busy_cnt;
        int led_hi;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dh = 1'b1;
            step();
            n_checks++;
            if (Nivel_hambre !== 2'(2 - i) || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL hambre_decay[%0d]: got lvl %0d obs %b expected lvl %0d obs %b",
                         i, Nivel_hambre, obs, 2 - i, exp_vec());
            end
        end
        dh = 1'b0;
        busy_cnt = 0;
        led_hi = 0;
        for (int c = 0; c < 40; c++) begin
            bf = (c < 20) ? 1'b0 : 1'b1;
            step();
            busy_cnt += busy;
            led_hi += Led_hambre;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL feed_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (busy_cnt != 9 || Nivel_hambre !== 2'd1 || led_hi != 0) begin
            n_fail++;
            $display("FAIL feed_summary: busy=%0d lvl=%0d led_hi=%0d expected 9,1,0",
                     busy_cnt, Nivel_hambre, led_hi);
        end
    endtask

    task automatic test_glitch();
        int busy_cnt;
        do_reset();
        busy_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            bp = (c < 30 && (c % 6) < 3) ? 1'b0 : 1'b1;
            step();
            busy_cnt += busy;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (busy_cnt != 0 || Nivel_animo !== 2'd3) begin
            n_fail++;
            $display("FAIL glitch_summary: busy=%0d animo=%0d expected 0,3",
                     busy_cnt, Nivel_animo);
        end
    endtask

    task automatic test_priority();
        do_reset();
        dh = 1'b1; dsa = 1'b1;
        step();
        step();
        dh = 1'b0; dsa = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bf = (c < 10) ? 1'b0 : 1'b1;
            bh = bf;
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL priority_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (Nivel_hambre !== 2'd2 || Nivel_salud !== 2'd1) begin
            n_fail++;
            $display("FAIL priority_summary: hambre=%0d salud=%0d expected 2,1",
                     Nivel_hambre, Nivel_salud);
        end
    endtask

    task automatic test_cooldown_drop();
        do_reset();
        ds = 1'b1;
        step();
        step();
        ds = 1'b0;
        for (int c = 0; c < 42; c++) begin
            bs = (c < 4 || (c >= 8 && c < 12)) ? 1'b0 : 1'b1;
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL cooldown_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (Nivel_sueno !== 2'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cooldown_summary: sueno=%0d busy=%b expected 2,0", Nivel_sueno, busy);
        end
    endtask

    task automatic test_apply_with_decay();
        bit seen;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                for (int k = 0; k < 3; k++) begin
                    da = 1'b1;
                    step();
                    da = 1'b0;
                    step();
                end
            end
            bp = 1'b0;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                seen = busy;
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL apply_decay_wait[%0d]: busy never rose, expected 1", pass);
            end
            da = 1'b1;
            step();
            da = 1'b0;
            n_checks++;
            if (Nivel_animo !== 2'(pass == 0 ? 3 : 0) || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL apply_decay[%0d]: got animo %0d obs %b expected animo %0d obs %b",
                         pass, Nivel_animo, obs, pass == 0 ? 3 : 0, exp_vec());
            end
            bp = 1'b1;
            for (int c = 0; c < 20; c++) step();
            n_checks++;
            if (obs !== exp_vec() || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL apply_decay_after[%0d]: got %b expected %b", pass, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_in_apply();
        bit seen;
        do_reset();
        dh = 1'b1;
        step();
        dh = 1'b0;
        bf = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            seen = busy;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_apply_wait: busy never rose, expected 1");
        end
        rst = 1'b1;
        bf  = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (obs[12:4] !== 9'b11111111_0) begin
            n_fail++;
            $display("FAIL reset_apply_state: got %b expected 111111110", obs[12:4]);
        end
        dh = 1'b1;
        step();
        dh = 1'b0;
        for (int c = 0; c < 30; c++) step();
        n_checks++;
        if (Nivel_hambre !== 2'd2 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_apply_after: hambre=%0d obs %b expected 2 obs %b",
                     Nivel_hambre, obs, exp_vec());
        end
    endtask

    task automatic test_held_through_reset();
        bs  = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) step();
        rst = 1'b0;
        ds  = 1'b1;
        step();
        step();
        ds  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL held_reset_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (Nivel_sueno !== 2'd2) begin
            n_fail++;
            $display("FAIL held_reset_summary: sueno=%0d expected 2", Nivel_sueno);
        end
        bs = 1'b1;
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 5) == 0) bf = ~bf;
            if ($urandom_range(0, 5) == 0) bs = ~bs;
            if ($urandom_range(0, 5) == 0) bp = ~bp;
            if ($urandom_range(0, 5) == 0) bh = ~bh;
            da  = ($urandom_range(0, 9) == 0);
            dh  = ($urandom_range(0, 9) == 0);
            ds  = ($urandom_range(0, 9) == 0);
            dsa = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle[%0d]: got %b expected %b", c, obs, exp_vec());
            end
        end
        rst = 1'b0;
        da = 1'b0; dh = 1'b0; ds = 1'b0; dsa = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decay_then_feed();
        test_glitch();
        test_priority();
        test_cooldown_drop();
        test_apply_with_decay();
        test_reset_in_apply();
        test_held_through_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/cuidado_mascota.md
CUIDADO_MASCOTA -- requirements
Module: cuidado_mascota

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable clk cycles required to accept a button level change.
REQ-002 Parameter COOLDOWN_CYCLES, default 32, number of clk cycles after an applied action during which new presses are dropped.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_feed  input  1  raw pushbutton, active-low, asynchronous to clk; restores hambre.
REQ-006 btn_sleep  input  1  raw pushbutton, active-low, asynchronous; restores sueno.
REQ-007 btn_play  input  1  raw pushbutton, active-low, asynchronous; restores animo.
REQ-008 btn_heal  input  1  raw pushbutton, active-low, asynchronous; restores salud.
REQ-009 dec_animo, dec_hambre, dec_sueno, dec_salud  input  1 each  one-cycle decay pulses from the decay block.
REQ-010 Nivel_animo, Nivel_hambre, Nivel_sueno, Nivel_salud  output  2 each  current need levels, 0 to 3.
REQ-011 busy  output  1  high while the FSM is not IDLE.
REQ-012 Led_animo, Led_hambre, Led_sueno, Led_salud  output  1 each  active-low; driven low when the matching level is below 3.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening glitch SHALL restart the count at 0.
REQ-015 A press event SHALL be a one-cycle pulse on each 1-to-0 transition of a debounced level; a release SHALL produce no event, and a held button SHALL produce exactly one event.
REQ-016 FSM states: IDLE, APPLY, COOLDOWN; busy = (state != IDLE).
REQ-017 IDLE: on any press event, the FSM SHALL latch one action and go to APPLY next cycle.
REQ-018 Action priority on simultaneous events: feed > sleep > play > heal; lower-priority events that cycle SHALL be discarded.
REQ-019 APPLY lasts exactly one cycle: the selected level SHALL be incremented by 1, saturating at 3; the FSM SHALL then load the cooldown counter with COOLDOWN_CYCLES-1 and enter COOLDOWN.
REQ-020 COOLDOWN: the counter SHALL decrement each cycle, and the FSM SHALL enter IDLE on the cycle after the counter equals 0; press events arriving in APPLY or COOLDOWN SHALL be dropped, not queued.
REQ-021 Decay pulses SHALL act in every state: each pulse decrements its level by 1 per cycle, saturating at 0.
REQ-022 If an increment and a decay hit the same level in the same cycle, the level SHALL be unchanged, even at the 0 or 3 bounds.
REQ-023 Level arithmetic SHALL be 2-bit with explicit saturation; wrap-around (3 to 0 or 0 to 3) SHALL never occur.
REQ-024 LED outputs SHALL be registered, reflecting levels with 1 cycle of latency.
REQ-025 Debounce counters SHALL be sized $clog2(DEBOUNCE_CYCLES+1) bits, and the cooldown counter $clog2(COOLDOWN_CYCLES+1) bits.

Reset
REQ-026 When rst is high at posedge clk, all levels SHALL be set to 3, the FSM to IDLE, busy to 0, all LEDs to 1, all counters to 0, and synchronizer and debounced levels to 1 (released).
REQ-027 Reset mid-APPLY or mid-COOLDOWN SHALL abort the action with no level change; the next cycle SHALL be IDLE.
REQ-028 A button held low through reset release SHALL produce exactly one press event after debounce.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-029 After reset, 3 dec_hambre pulses, then btn_feed held low for 20 cycles -> Nivel_hambre goes 3,2,1,0, then 1 after one APPLY; busy is high for exactly 9 cycles; Led_hambre stays 0.
REQ-030 btn_play toggled with 3-cycle low glitches for 30 cycles, then held high -> no press event, Nivel_animo stays 3, busy stays 0.
REQ-031 btn_feed and btn_heal pressed in the same cycle with Nivel_hambre=Nivel_salud=1 -> Nivel_hambre=2, Nivel_salud=1.
REQ-032 A second btn_sleep press debounced during COOLDOWN -> dropped; Nivel_sueno rises by exactly 1 in total.
REQ-033 APPLY on animo coincides with a dec_animo pulse at level 3 -> level stays 3; at level 0 -> level stays 0.
REQ-034 rst asserted in the cycle the FSM is in APPLY -> all levels 3, busy 0 on the next cycle, and no extra increment afterwards.
